// File: rtl/rv_wb_pkg.sv
// Shared definitions for the writeback stage: write-kind encodings,
// FSM state type and fixed widths of the register-file write ports.
package rv_wb_pkg;

  localparam int XLEN       = 32;
  localparam int MWIDTH     = 128;
  localparam int RF_AW      = 5;
  localparam int MRF_AW     = 3;
  localparam int BEAT_COUNT = 4;

  localparam logic [1:0] W_SEL_NONE   = 2'b00;
  localparam logic [1:0] W_SEL_SCALAR = 2'b01;
  localparam logic [1:0] W_SEL_MBURST = 2'b10;
  localparam logic [1:0] W_SEL_MFILE  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_word_sel.sv
// Picks one 32-bit word out of a 128-bit matrix result.
// order 0 walks words low to high, order 1 walks them high to low.
module wb_word_sel
  import rv_wb_pkg::*;
(
  input  logic [MWIDTH-1:0] data_i,
  input  logic [1:0]        beat_i,
  input  logic              order_i,
  output logic [XLEN-1:0]   word_o
);

  logic [1:0] idx;

  // Reversing the order is just the bitwise complement of a 2-bit beat index.
  always_comb begin
    idx    = order_i ? ~beat_i : beat_i;
    word_o = data_i[{idx, 5'b00000} +: XLEN];
  end

endmodule

// File: rtl/wb_writeback_unit.sv
// Writeback stage: drives the scalar (32x32) and matrix (8x128) register
// file write ports from the MEM/WB register. A matrix->scalar op is
// serialised into four beats to consecutive scalar registers while the
// upstream register is stalled.
// Optional macro WB_TRACE_EN: prints every register-file write (simulation only).
//
// Upstream handshake: stall_o high means the MEM/WB register must hold its
// contents and the wb_* inputs are ignored; any op presented while stall_o is
// low is consumed at the next rising edge, exactly once.
module wb_writeback_unit
  import rv_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   wb_mem_data,
  input  logic [XLEN-1:0]   wb_alu_o,
  input  logic [MWIDTH-1:0] wb_matrix_o,
  input  logic [RF_AW-1:0]  wb_rd,
  input  logic              wb_mem2reg,
  input  logic [1:0]        wb_w_select,
  input  logic              wb_rs2_r_select,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              mrf_we,
  output logic [MRF_AW-1:0] mrf_waddr,
  output logic [MWIDTH-1:0] mrf_wdata,
  output logic              stall_o,
  output logic              busy_o
);

  wb_state_e         state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [MWIDTH-1:0] buf_data_q, buf_data_d;
  logic [RF_AW-1:0]  buf_rd_q, buf_rd_d;
  logic              buf_order_q, buf_order_d;

  logic              rf_we_q, rf_we_d;
  logic [RF_AW-1:0]  rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              mrf_we_q, mrf_we_d;
  logic [MRF_AW-1:0] mrf_waddr_q, mrf_waddr_d;
  logic [MWIDTH-1:0] mrf_wdata_q, mrf_wdata_d;

  logic [MWIDTH-1:0] sel_data;
  logic [1:0]        sel_beat;
  logic              sel_order;
  logic [XLEN-1:0]   sel_word;
  logic [RF_AW-1:0]  beat_addr;

  // Beat source: the live inputs for beat 0, the latched buffer afterwards.
  always_comb begin
    if (state_q == ST_BURST) begin
      sel_data  = buf_data_q;
      sel_beat  = beat_q;
      sel_order = buf_order_q;
      beat_addr = buf_rd_q + {3'b000, beat_q};
    end else begin
      sel_data  = wb_matrix_o;
      sel_beat  = 2'd0;
      sel_order = wb_rs2_r_select;
      beat_addr = wb_rd;
    end
  end

  wb_word_sel u_word_sel (
    .data_i  (sel_data),
    .beat_i  (sel_beat),
    .order_i (sel_order),
    .word_o  (sel_word)
  );

  // Next-state and next-output logic; write data/addresses hold unless written.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    buf_data_d  = buf_data_q;
    buf_rd_d    = buf_rd_q;
    buf_order_d = buf_order_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    mrf_we_d    = 1'b0;
    mrf_waddr_d = mrf_waddr_q;
    mrf_wdata_d = mrf_wdata_q;
    case (state_q)
      ST_IDLE: begin
        case (wb_w_select)
          W_SEL_SCALAR: begin
            rf_we_d    = (wb_rd != '0);
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_mem2reg ? wb_mem_data : wb_alu_o;
          end
          W_SEL_MFILE: begin
            mrf_we_d    = 1'b1;
            mrf_waddr_d = wb_rd[MRF_AW-1:0];
            mrf_wdata_d = wb_matrix_o;
          end
          W_SEL_MBURST: begin
            buf_data_d  = wb_matrix_o;
            buf_rd_d    = wb_rd;
            buf_order_d = wb_rs2_r_select;
            rf_we_d     = (beat_addr != '0);
            rf_waddr_d  = beat_addr;
            rf_wdata_d  = sel_word;
            beat_d      = 2'd1;
            state_d     = ST_BURST;
          end
          default: ;
        endcase
      end
      ST_BURST: begin
        // x0 beats still use up their slot, only the enable is dropped.
        rf_we_d    = (beat_addr != '0);
        rf_waddr_d = beat_addr;
        rf_wdata_d = sel_word;
        if (beat_q == 2'(BEAT_COUNT - 1)) begin
          beat_d  = 2'd0;
          state_d = ST_IDLE;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, burst buffer and registered write ports; reset abandons any burst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= 2'd0;
      buf_data_q  <= '0;
      buf_rd_q    <= '0;
      buf_order_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      mrf_we_q    <= 1'b0;
      mrf_waddr_q <= '0;
      mrf_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      buf_data_q  <= buf_data_d;
      buf_rd_q    <= buf_rd_d;
      buf_order_q <= buf_order_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      mrf_we_q    <= mrf_we_d;
      mrf_waddr_q <= mrf_waddr_d;
      mrf_wdata_q <= mrf_wdata_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign mrf_we    = mrf_we_q;
  assign mrf_waddr = mrf_waddr_q;
  assign mrf_wdata = mrf_wdata_q;
  assign stall_o   = (state_q == ST_BURST);
  assign busy_o    = (state_q == ST_BURST);

`ifdef WB_TRACE_EN
  // Trace each write presented to either register file.
  always @(posedge clk) begin
    if (rf_we_q)
      $display("[%0t] wb rf  x%0d <= %h", $time, rf_waddr_q, rf_wdata_q);
    if (mrf_we_q)
      $display("[%0t] wb mrf m%0d <= %h", $time, mrf_waddr_q, mrf_wdata_q);
  end
`else
`endif

endmodule
